// File: rtl/fnd_scan_ctrl.sv
// rtl/fnd_scan_ctrl.sv - APB scan controller for a 4-digit common-anode multiplexed FND
module fnd_scan_ctrl #(
    parameter int          BLANK_CYC = 4,
    parameter logic [15:0] DIV_RST   = 16'd49999
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [3:0]  PADDR,
    input  logic [31:0] PWDATA,
    input  logic        PWRITE,
    input  logic        PENABLE,
    input  logic        PSEL,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic [3:0]  fndComm,
    output logic [7:0]  fndFont
);

    typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

    localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYC - 1);

    state_t      state;
    logic        en, lzb;
    logic [15:0] fdiv, fdr;
    logic [3:0]  fdp;
    logic [15:0] sh_dat, sh_div, cnt;
    logic [3:0]  sh_dp;
    logic [1:0]  digit;

    logic        apb_access, apb_wr, apb_rd, en_nxt, busy, dark;
    logic [15:0] eff_div;
    logic [31:0] rdata;
    logic [3:0]  code, lz, disp_comm;
    logic [7:0]  disp_font;
    logic        unused_bits;

    function automatic logic [6:0] seg7(input logic [3:0] c);
        case (c)
            4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
        endcase
    endfunction

    assign apb_access  = PSEL & PENABLE & ~PREADY;
    assign apb_wr      = apb_access & PWRITE;
    assign apb_rd      = apb_access & ~PWRITE;
    // A disable written this very cycle overrides whatever the scan FSM would do
    assign en_nxt      = (apb_wr && PADDR[3:2] == 2'd0) ? PWDATA[0] : en;
    assign busy        = (state != IDLE);
    assign eff_div     = (fdiv == 16'd0) ? 16'd1 : fdiv;
    assign unused_bits = ^{PWDATA[31:16], PADDR[1:0]};

    always_comb begin
        rdata = 32'd0;
        case (PADDR[3:2])
            2'd0: rdata = {21'd0, busy, digit, 6'd0, lzb, en};
            2'd1: rdata = {16'd0, fdiv};
            2'd2: rdata = {16'd0, fdr};
            default: rdata = {28'd0, fdp};
        endcase
    end

    // Leading-zero detection runs on the shadow copy so a frame is blanked consistently
    always_comb begin
        code      = 4'(sh_dat >> {digit, 2'b00});
        lz[3]     = (sh_dat[15:12] == 4'd0);
        lz[2]     = lz[3] && (sh_dat[11:8] == 4'd0);
        lz[1]     = lz[2] && (sh_dat[7:4] == 4'd0);
        lz[0]     = 1'b0;
        dark      = lzb & lz[digit];
        disp_comm = dark ? 4'hF : ~(4'b0001 << digit);
        disp_font = dark ? 8'hFF : {~sh_dp[digit], seg7(code)};
    end

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            en     <= 1'b0;
            lzb    <= 1'b0;
            fdiv   <= DIV_RST;
            fdr    <= 16'd0;
            fdp    <= 4'd0;
            PREADY <= 1'b0;
            PRDATA <= 32'd0;
        end else begin
            PREADY <= apb_access;
            if (apb_rd)
                PRDATA <= rdata;
            if (apb_wr) begin
                case (PADDR[3:2])
                    2'd0: begin en <= PWDATA[0]; lzb <= PWDATA[1]; end
                    2'd1: fdiv <= PWDATA[15:0];
                    2'd2: fdr  <= PWDATA[15:0];
                    default: fdp <= PWDATA[3:0];
                endcase
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state   <= IDLE;
            digit   <= 2'd0;
            cnt     <= 16'd0;
            sh_dat  <= 16'd0;
            sh_dp   <= 4'd0;
            sh_div  <= 16'd0;
            fndComm <= 4'hF;
            fndFont <= 8'hFF;
        end else if (!en_nxt) begin
            state   <= IDLE;
            digit   <= 2'd0;
            cnt     <= 16'd0;
            fndComm <= 4'hF;
            fndFont <= 8'hFF;
        end else begin
            fndComm <= (state == SHOW) ? disp_comm : 4'hF;
            fndFont <= (state == SHOW) ? disp_font : 8'hFF;
            case (state)
                IDLE: begin
                    if (en) begin
                        state  <= SHOW;
                        digit  <= 2'd0;
                        cnt    <= 16'd0;
                        sh_dat <= fdr;
                        sh_dp  <= fdp;
                        sh_div <= eff_div;
                    end
                end
                SHOW: begin
                    if (cnt == sh_div) begin
                        cnt   <= 16'd0;
                        state <= BLANK;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    if (cnt == BLANK_LAST) begin
                        cnt    <= 16'd0;
                        digit  <= digit + 2'd1;
                        state  <= SHOW;
                        sh_div <= eff_div;
                        if (digit == 2'd3) begin
                            sh_dat <= fdr;
                            sh_dp  <= fdp;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// tb/tb_fnd_scan_ctrl.sv - scoreboard bench for fnd_scan_ctrl
module tb_fnd_scan_ctrl;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b0;
    logic [3:0]  PADDR = 4'd0;
    logic [31:0] PWDATA = 32'd0;
    logic        PWRITE = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PSEL = 1'b0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic [3:0]  fndComm;
    logic [7:0]  fndFont;

    int n_assert = 0;
    int n_fail = 0;
    logic [11:0] exp_q[$];

    localparam logic [3:0] A_FCR = 4'h0, A_FDIV = 4'h4, A_FDR = 4'h8, A_FDP = 4'hC;

    fnd_scan_ctrl #(.BLANK_CYC(4), .DIV_RST(16'd49999)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWDATA(PWDATA),
        .PWRITE(PWRITE), .PENABLE(PENABLE), .PSEL(PSEL), .PRDATA(PRDATA),
        .PREADY(PREADY), .fndComm(fndComm), .fndFont(fndFont)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] seg_ref(input logic [3:0] c);
        logic [7:0] t [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        return t[c];
    endfunction

    task automatic apb_xfer(input bit wr, input logic [3:0] addr, input logic [31:0] wd,
                            output logic [31:0] rd);
        int n;
        @(negedge PCLK);
        PSEL = 1'b1; PWRITE = wr; PADDR = addr; PWDATA = wd; PENABLE = 1'b0;
        @(negedge PCLK);
        PENABLE = 1'b1;
        n = 0;
        do begin
            @(negedge PCLK);
            n++;
        end while (!PREADY && n < 8);
        if (!PREADY) begin
            n_assert++; n_fail++;
            $display("FAIL apb_timeout: PREADY=%b required 1 addr=%h", PREADY, addr);
        end
        rd = PRDATA;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_write(input logic [3:0] addr, input logic [31:0] wd);
        logic [31:0] dummy;
        apb_xfer(1'b1, addr, wd, dummy);
    endtask

    task automatic push_frame(input logic [15:0] dat, input logic [3:0] dp, input bit lzb, input int on);
        logic [7:0] f;
        bit dark;
        for (int d = 0; d < 4; d++) begin
            dark = lzb && d > 0 && ((dat >> (4 * d)) == 16'd0);
            f = seg_ref(dat[d*4 +: 4]) & (dp[d] ? 8'h7F : 8'hFF);
            for (int k = 0; k < on; k++)
                exp_q.push_back(dark ? 12'hFFF : {~(4'b0001 << d), f});
            for (int k = 0; k < 4; k++)
                exp_q.push_back(12'hFFF);
        end
    endtask

    task automatic run_scoreboard(input string name, input int max_wait);
        int waited;
        int idx;
        logic [11:0] e;
        waited = 0;
        @(negedge PCLK);
        while (fndComm == 4'hF && waited < max_wait) begin
            @(negedge PCLK);
            waited++;
        end
        if (fndComm == 4'hF) begin
            n_assert++; n_fail++;
            $display("FAIL %s_start: comm=%b required a lit digit within %0d cycles", name, fndComm, max_wait);
            exp_q.delete();
            return;
        end
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_assert++;
            if ({fndComm, fndFont} !== e) begin
                n_fail++;
                $display("FAIL %s[%0d]: comm=%b font=%h required comm=%b font=%h",
                         name, idx, fndComm, fndFont, e[11:8], e[7:0]);
            end
            idx++;
            @(negedge PCLK);
        end
    endtask

    task automatic wait_comm(input logic [3:0] pat, input string name);
        int n;
        n = 0;
        while (fndComm !== pat && n < 200) begin
            @(negedge PCLK);
            n++;
        end
        if (fndComm !== pat) begin
            n_assert++; n_fail++;
            $display("FAIL %s_wait: comm=%b required %b", name, fndComm, pat);
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        repeat (3) @(negedge PCLK);
        n_assert += 4;
        if (fndComm !== 4'hF) begin n_fail++; $display("FAIL rst_comm: %b required 1111", fndComm); end
        if (fndFont !== 8'hFF) begin n_fail++; $display("FAIL rst_font: %h required ff", fndFont); end
        if (PREADY !== 1'b0) begin n_fail++; $display("FAIL rst_pready: %b required 0", PREADY); end
        if (PRDATA !== 32'd0) begin n_fail++; $display("FAIL rst_prdata: %h required 0", PRDATA); end
        PRESET = 1'b1;
        apb_xfer(1'b0, A_FDIV, 32'd0, rd);
        n_assert++;
        if (rd !== 32'h0000C34F) begin n_fail++; $display("FAIL rst_fdiv: %h required 0000c34f", rd); end
        apb_xfer(1'b0, A_FCR, 32'd0, rd);
        n_assert++;
        if (rd !== 32'd0) begin n_fail++; $display("FAIL rst_fcr: %h required 0", rd); end
    endtask

    task automatic test_apb();
        logic [31:0] rd;
        @(negedge PCLK);
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = A_FDP; PWDATA = 32'h5; PENABLE = 1'b0;
        n_assert++;
        if (PREADY !== 1'b0) begin n_fail++; $display("FAIL apb_setup_ready: %b required 0", PREADY); end
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(negedge PCLK);
        n_assert++;
        if (PREADY !== 1'b1) begin n_fail++; $display("FAIL apb_access_ready: %b required 1", PREADY); end
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        @(negedge PCLK);
        n_assert++;
        if (PREADY !== 1'b0) begin n_fail++; $display("FAIL apb_ready_drop: %b required 0", PREADY); end
        apb_xfer(1'b0, A_FDP, 32'd0, rd);
        n_assert++;
        if (rd !== 32'h5) begin n_fail++; $display("FAIL apb_fdp_read: %h required 5", rd); end
        @(negedge PCLK);
        n_assert++;
        if (PRDATA !== 32'h5) begin n_fail++; $display("FAIL apb_prdata_hold: %h required 5", PRDATA); end
        apb_write(A_FDP, 32'h0);
        apb_write(A_FDIV, 32'h0);
        push_frame(16'h0000, 4'h0, 1'b0, 2);
        apb_write(A_FCR, 32'h1);
        run_scoreboard("fdiv_zero", 20);
        apb_write(A_FCR, 32'h0);
    endtask

    task automatic test_basic_scan();
        logic [31:0] rd;
        apb_write(A_FDIV, 32'd3);
        apb_write(A_FDR, 32'h1234);
        apb_write(A_FDP, 32'h0);
        push_frame(16'h1234, 4'h0, 1'b0, 4);
        push_frame(16'h1234, 4'h0, 1'b0, 4);
        apb_write(A_FCR, 32'h1);
        run_scoreboard("basic", 20);
        wait_comm(4'b1011, "digit_read");
        apb_xfer(1'b0, A_FCR, 32'd0, rd);
        n_assert++;
        if (rd[10:8] !== 3'b110) begin n_fail++; $display("FAIL fcr_digit: busy/digit=%b required 110", rd[10:8]); end
        apb_write(A_FCR, 32'h0);
    endtask

    task automatic test_tear_free();
        apb_write(A_FDR, 32'h1234);
        push_frame(16'h1234, 4'h0, 1'b0, 4);
        push_frame(16'hABCD, 4'h0, 1'b0, 4);
        apb_write(A_FCR, 32'h1);
        fork
            run_scoreboard("tear", 20);
            begin
                wait_comm(4'b1101, "tear_digit1");
                apb_write(A_FDR, 32'hABCD);
            end
        join
        apb_write(A_FCR, 32'h0);
    endtask

    task automatic test_lzb_dp();
        apb_write(A_FDR, 32'h0050);
        apb_write(A_FDP, 32'h2);
        push_frame(16'h0050, 4'b0010, 1'b1, 4);
        apb_write(A_FCR, 32'h3);
        run_scoreboard("lzb_dp", 20);
        apb_write(A_FCR, 32'h0);
        apb_write(A_FDP, 32'h0);
    endtask

    task automatic test_disable();
        logic [31:0] rd;
        apb_write(A_FDR, 32'h1234);
        apb_write(A_FCR, 32'h1);
        wait_comm(4'b1011, "dis_digit2");
        apb_write(A_FCR, 32'h0);
        @(negedge PCLK);
        n_assert += 2;
        if (fndComm !== 4'hF) begin n_fail++; $display("FAIL dis_comm: %b required 1111", fndComm); end
        if (fndFont !== 8'hFF) begin n_fail++; $display("FAIL dis_font: %h required ff", fndFont); end
        apb_xfer(1'b0, A_FCR, 32'd0, rd);
        n_assert++;
        if (rd !== 32'd0) begin n_fail++; $display("FAIL dis_fcr: %h required 0", rd); end
        push_frame(16'h1234, 4'h0, 1'b0, 4);
        apb_write(A_FCR, 32'h1);
        run_scoreboard("reenable", 20);
    endtask

    task automatic test_midscan_reset();
        logic [31:0] rd;
        wait_comm(4'b0111, "rst_digit3");
        #3;
        PRESET = 1'b0;
        #1;
        n_assert += 2;
        if (fndComm !== 4'hF) begin n_fail++; $display("FAIL mrst_comm: %b required 1111", fndComm); end
        if (fndFont !== 8'hFF) begin n_fail++; $display("FAIL mrst_font: %h required ff", fndFont); end
        @(negedge PCLK);
        PRESET = 1'b1;
        apb_xfer(1'b0, A_FDIV, 32'd0, rd);
        n_assert++;
        if (rd !== 32'h0000C34F) begin n_fail++; $display("FAIL mrst_fdiv: %h required 0000c34f", rd); end
        apb_xfer(1'b0, A_FCR, 32'd0, rd);
        n_assert++;
        if (rd !== 32'd0) begin n_fail++; $display("FAIL mrst_fcr: %h required 0", rd); end
    endtask

    initial begin
        test_reset();
        test_apb();
        test_basic_scan();
        test_tear_free();
        test_lzb_dp();
        test_disable();
        test_midscan_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
